// File: rtl/preg_reclaim_unit_pkg.sv
// rtl/preg_reclaim_unit_pkg.sv - shared physical-register ID types for the free list, rename and reclaim
//
// Purpose : common preg ID type and constants shared by the free list, rename stage and reclaim unit.
// Contents: PREG_ID_W   default physical register ID width
//           preg_id_t   physical register ID
//           PREG_ZERO   ID of the hard-wired x0 mapping, never recycled
//           sum2()      population count of two single-bit flags
package preg_reclaim_unit_pkg;

    localparam int PREG_ID_W = 7;

    typedef logic [PREG_ID_W-1:0] preg_id_t;

    localparam preg_id_t PREG_ZERO = '0;

    function automatic logic [1:0] sum2(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/preg_reclaim_unit_sva.sv
// rtl/preg_reclaim_unit_sva.sv - bound safety properties for the reclaim staging buffer
//
// Purpose : checks occupancy bounds and the free list push protocol.
// Ports   : clk, rst, fl_ready, fl_push, fl_push_2, occupancy (all observed, none driven)
`ifdef INCLUDE_SVAS
module preg_reclaim_unit_sva #(
    parameter int DEPTH = 8
) (
    input logic                       clk,
    input logic                       rst,
    input logic                       fl_ready,
    input logic                       fl_push,
    input logic                       fl_push_2,
    input logic [$clog2(DEPTH+1)-1:0] occupancy
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        occupancy <= ($clog2(DEPTH+1))'(DEPTH));

    // Popping more than is held would wrap the unsigned counter.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        (fl_push_2 |-> occupancy >= 2) and (fl_push |-> occupancy >= 1));

    a_no_push_unready: assert property (@(posedge clk) disable iff (!rst)
        !fl_ready |-> !(fl_push || fl_push_2));

    a_push2_needs_push: assert property (@(posedge clk) disable iff (!rst)
        fl_push_2 |-> fl_push);

endmodule

bind preg_reclaim_unit preg_reclaim_unit_sva #(.DEPTH(DEPTH)) u_sva (
    .clk       (clk),
    .rst       (rst),
    .fl_ready  (fl_ready),
    .fl_push   (fl_push),
    .fl_push_2 (fl_push_2),
    .occupancy (occupancy)
);
`endif

// File: rtl/preg_reclaim_unit.sv
// rtl/preg_reclaim_unit.sv - staging buffer feeding freed physical register IDs to the free list
//
// Purpose : accepts up to two freed preg IDs per cycle from commit, filters out the x0 mapping,
//           compacts them in age order and drains up to two per cycle into the free list.
// Ports   : clk, rst (async, active-low)
//           rel_valid_1/rel_preg_1, rel_valid_2/rel_preg_2  commit release slots (slot 1 older)
//           rel_ready                                       room for two IDs this cycle
//           fl_push/fl_push_data, fl_push_2/fl_push_data_2  free list push channels
//           fl_ready                                        free list can take pushes
//           occupancy, empty                                buffer fill status
module preg_reclaim_unit
    import preg_reclaim_unit_pkg::*;
#(
    parameter int DATA_WIDTH = PREG_ID_W,
    parameter int DEPTH      = 8,
    parameter bit DROP_ZERO  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rel_valid_1,
    input  logic [DATA_WIDTH-1:0]      rel_preg_1,
    input  logic                       rel_valid_2,
    input  logic [DATA_WIDTH-1:0]      rel_preg_2,
    output logic                       rel_ready,
    output logic [DATA_WIDTH-1:0]      fl_push_data,
    output logic                       fl_push,
    output logic [DATA_WIDTH-1:0]      fl_push_data_2,
    output logic                       fl_push_2,
    input  logic                       fl_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic          zero_1, zero_2;
    logic          keep_1, keep_2;
    logic [1:0]    n_in, n_out;
    logic [PW-1:0] slot2_ptr;
    logic [PW-1:0] rd_ptr_p1;

    // Readiness looks only at registered count so there is no path from fl_ready to rel_ready.
    assign rel_ready = (count_q <= CW'(DEPTH-2));

    assign zero_1 = DROP_ZERO && (rel_preg_1 == DATA_WIDTH'(PREG_ZERO));
    assign zero_2 = DROP_ZERO && (rel_preg_2 == DATA_WIDTH'(PREG_ZERO));
    assign keep_1 = rel_valid_1 & rel_ready & ~zero_1;
    assign keep_2 = rel_valid_2 & rel_ready & ~zero_2;
    assign n_in   = sum2(keep_1, keep_2);

    // Slot 2 lands directly at the write pointer when slot 1 was not kept, so no holes appear.
    assign slot2_ptr = wr_ptr_q + PW'(keep_1);

    assign fl_push   = fl_ready & (count_q != '0);
    assign fl_push_2 = fl_ready & (count_q >= CW'(2));
    assign n_out     = sum2(fl_push, fl_push_2);

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    assign rd_ptr_p1      = rd_ptr_q + PW'(1);
    assign fl_push_data   = fl_push   ? mem_q[rd_ptr_q]  : '0;
    assign fl_push_data_2 = fl_push_2 ? mem_q[rd_ptr_p1] : '0;

    assign wr_ptr_d = wr_ptr_q + PW'(n_in);
    assign rd_ptr_d = rd_ptr_q + PW'(n_out);
    assign count_d  = count_q + CW'(n_in) - CW'(n_out);

    assign occupancy = count_q;
    assign empty     = (count_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are gated by count, which is reset.
    always_ff @(posedge clk) begin
        if (keep_1) mem_q[wr_ptr_q]  <= rel_preg_1;
        if (keep_2) mem_q[slot2_ptr] <= rel_preg_2;
    end

endmodule

// File: tb/tb_preg_reclaim_unit.sv
// tb/tb_preg_reclaim_unit.sv - self-checking bench for preg_reclaim_unit
module tb_preg_reclaim_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       rel_valid_1, rel_valid_2;
    logic [6:0] rel_preg_1, rel_preg_2;
    logic       rel_ready;
    logic [6:0] fl_push_data, fl_push_data_2;
    logic       fl_push, fl_push_2;
    logic       fl_ready;
    logic [3:0] occupancy;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    preg_reclaim_unit #(.DATA_WIDTH(7), .DEPTH(8), .DROP_ZERO(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .rel_valid_1    (rel_valid_1),
        .rel_preg_1     (rel_preg_1),
        .rel_valid_2    (rel_valid_2),
        .rel_preg_2     (rel_preg_2),
        .rel_ready      (rel_ready),
        .fl_push_data   (fl_push_data),
        .fl_push        (fl_push),
        .fl_push_data_2 (fl_push_data_2),
        .fl_push_2      (fl_push_2),
        .fl_ready       (fl_ready),
        .occupancy      (occupancy),
        .empty          (empty)
    );

    typedef struct {
        int rst_n, v1, p1, v2, p2, flr;
        int e_push, e_d1, e_push2, e_d2, e_ready, e_occ, e_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addv(input int rst_n, input int v1, input int p1, input int v2, input int p2,
                        input int flr, input int e_push, input int e_d1, input int e_push2,
                        input int e_d2, input int e_ready, input int e_occ, input int e_empty);
        vec_t v;
        v = '{rst_n, v1, p1, v2, p2, flr, e_push, e_d1, e_push2, e_d2, e_ready, e_occ, e_empty};
        vecs.push_back(v);
    endtask

    task automatic drive(input int rst_n, input int v1, input int p1, input int v2, input int p2,
                         input int flr);
        rst         = rst_n[0];
        rel_valid_1 = v1[0];
        rel_preg_1  = p1[6:0];
        rel_valid_2 = v2[0];
        rel_preg_2  = p2[6:0];
        fl_ready    = flr[0];
    endtask

    int q[$];
    int next_id;

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        //    rst v1 p1  v2 p2 flr | push d1 push2 d2 ready occ empty
        addv(0, 1, 5,  0, 0,  1,    0, 0,  0, 0,  1, 0, 1);  // reset with release held
        addv(1, 0, 0,  0, 0,  1,    0, 0,  0, 0,  1, 0, 1);  // idle after reset
        addv(1, 1, 40, 1, 41, 1,    0, 0,  0, 0,  1, 0, 1);  // dual release, no bypass
        addv(1, 0, 0,  0, 0,  1,    1, 40, 1, 41, 1, 2, 0);
        addv(1, 0, 0,  0, 0,  1,    0, 0,  0, 0,  1, 0, 1);
        addv(1, 1, 0,  1, 55, 1,    0, 0,  0, 0,  1, 0, 1);  // x0 filtered
        addv(1, 0, 0,  0, 0,  1,    1, 55, 0, 0,  1, 1, 0);
        addv(1, 0, 33, 1, 60, 1,    0, 0,  0, 0,  1, 0, 1);  // slot 2 alone
        addv(1, 0, 0,  0, 0,  1,    1, 60, 0, 0,  1, 1, 0);
        addv(1, 1, 10, 1, 11, 0,    0, 0,  0, 0,  1, 0, 1);  // backpressure fill
        addv(1, 1, 12, 1, 13, 0,    0, 0,  0, 0,  1, 2, 0);
        addv(1, 1, 14, 1, 15, 0,    0, 0,  0, 0,  1, 4, 0);
        addv(1, 1, 16, 0, 0,  0,    0, 0,  0, 0,  1, 6, 0);  // count 6 still ready
        addv(1, 1, 17, 1, 18, 0,    0, 0,  0, 0,  0, 7, 0);  // count 7 refuses
        addv(1, 0, 0,  0, 0,  1,    1, 10, 1, 11, 0, 7, 0);
        addv(1, 0, 0,  0, 0,  1,    1, 12, 1, 13, 1, 5, 0);
        addv(1, 0, 0,  0, 0,  1,    1, 14, 1, 15, 1, 3, 0);
        addv(1, 0, 0,  0, 0,  1,    1, 16, 0, 0,  1, 1, 0);
        addv(1, 0, 0,  0, 0,  1,    0, 0,  0, 0,  1, 0, 1);  // 17/18 were never taken

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].v1, vecs[i].p1, vecs[i].v2, vecs[i].p2, vecs[i].flr);
            #1;
            chk($sformatf("v%0d.push", i),  int'(fl_push),        vecs[i].e_push);
            chk($sformatf("v%0d.d1", i),    int'(fl_push_data),   vecs[i].e_d1);
            chk($sformatf("v%0d.push2", i), int'(fl_push_2),      vecs[i].e_push2);
            chk($sformatf("v%0d.d2", i),    int'(fl_push_data_2), vecs[i].e_d2);
            chk($sformatf("v%0d.ready", i), int'(rel_ready),      vecs[i].e_ready);
            chk($sformatf("v%0d.occ", i),   int'(occupancy),      vecs[i].e_occ);
            chk($sformatf("v%0d.empty", i), int'(empty),          vecs[i].e_empty);
            @(negedge clk);
        end

        // Wrap stress against a queue scoreboard: mixed 2-in/1-in with occasional stalls.
        q.delete();
        next_id = 1;
        for (int i = 0; i < 48; i++) begin
            int v1, v2, p1, p2, flr, np, ready_m;
            flr = (i % 5 != 4) ? 1 : 0;
            v1 = 1; v2 = 1;
            if (i >= 40) begin
                v1 = 0; v2 = 0; flr = 1;
            end else if (i % 3 == 2) begin
                if (i % 2 == 0) v2 = 0; else v1 = 0;
            end
            p1 = next_id; next_id = (next_id % 126) + 1;
            p2 = next_id; next_id = (next_id % 126) + 1;
            if (i % 7 == 3) p1 = 0;
            drive(1, v1, p1, v2, p2, flr);
            #1;
            np = (flr == 1) ? ((q.size() >= 2) ? 2 : q.size()) : 0;
            ready_m = (q.size() <= 6) ? 1 : 0;
            chk($sformatf("w%0d.occ", i),   int'(occupancy), q.size());
            chk($sformatf("w%0d.ready", i), int'(rel_ready), ready_m);
            chk($sformatf("w%0d.push", i),  int'(fl_push),   (np >= 1) ? 1 : 0);
            chk($sformatf("w%0d.push2", i), int'(fl_push_2), (np == 2) ? 1 : 0);
            chk($sformatf("w%0d.d1", i),    int'(fl_push_data),   (np >= 1) ? q[0] : 0);
            chk($sformatf("w%0d.d2", i),    int'(fl_push_data_2), (np == 2) ? q[1] : 0);
            for (int k = 0; k < np; k++) void'(q.pop_front());
            if (ready_m == 1 && v1 == 1 && p1 != 0) q.push_back(p1);
            if (ready_m == 1 && v2 == 1 && p2 != 0) q.push_back(p2);
            @(negedge clk);
        end
        drive(1, 0, 0, 0, 0, 1);
        #1;
        chk("wrap.final_occ", int'(occupancy), q.size());

        // Asynchronous reset with five IDs held.
        @(negedge clk);
        drive(1, 1, 1, 1, 2, 0);
        @(negedge clk);
        drive(1, 1, 3, 1, 4, 0);
        @(negedge clk);
        drive(1, 1, 5, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1);
        #1;
        chk("ar.pre_occ",  int'(occupancy),    5);
        chk("ar.pre_push", int'(fl_push),      1);
        chk("ar.pre_d1",   int'(fl_push_data), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar.push",  int'(fl_push),        0);
        chk("ar.d1",    int'(fl_push_data),   0);
        chk("ar.push2", int'(fl_push_2),      0);
        chk("ar.d2",    int'(fl_push_data_2), 0);
        chk("ar.occ",   int'(occupancy),      0);
        chk("ar.empty", int'(empty),          1);
        chk("ar.ready", int'(rel_ready),      1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar.post_empty", int'(empty), 1);
        @(negedge clk);
        #1;
        chk("ar.post_push",  int'(fl_push), 0);
        chk("ar.post_empty2", int'(empty),  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
